pipeline_sequencer: RTL and testbench

// Central hazard/sequence controller for the 5-stage SPARC pipeline. Drives the

---
 rtl/pipeline_sequencer_if.sv | 38 +++
 rtl/pipeline_sequencer.sv | 139 +++++++++++++
 tb/tb_pipeline_sequencer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_sequencer_if.sv
// Hazard/sequencing bundle between the 5-stage pipeline datapath and its sequencer.
// The datapath holds the master side; the sequencer holds the slave side.
interface pipeline_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       id_rs1, id_rs2, id_rd;
  logic             id_use_rs1, id_use_rs2, id_use_rd;
  logic             id_branch, id_a, branch_taken, id_call, id_jmpl;
  logic [4:0]       ex_rd, mem_rd, wb_rd;
  logic             ex_rf_en, mem_rf_en, wb_rf_en, ex_load;
  logic             mem_req, mem_ready;

  logic             pc_le, if_id_le, id_ex_le, ex_mem_le, mem_wb_le;
  logic             nop_sel, if_id_squash;
  logic [1:0]       forward_mx1, forward_mx2, forward_mx3, forward_pc;
  logic             mem_error;
  logic [CNT_W-1:0] stall_count, annul_count;

  modport master (
    output id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2, id_use_rd,
           id_branch, id_a, branch_taken, id_call, id_jmpl,
           ex_rd, mem_rd, wb_rd, ex_rf_en, mem_rf_en, wb_rf_en, ex_load,
           mem_req, mem_ready,
    input  pc_le, if_id_le, id_ex_le, ex_mem_le, mem_wb_le, nop_sel, if_id_squash,
           forward_mx1, forward_mx2, forward_mx3, forward_pc,
           mem_error, stall_count, annul_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2, id_use_rd,
           id_branch, id_a, branch_taken, id_call, id_jmpl,
           ex_rd, mem_rd, wb_rd, ex_rf_en, mem_rf_en, wb_rf_en, ex_load,
           mem_req, mem_ready,
    output pc_le, if_id_le, id_ex_le, ex_mem_le, mem_wb_le, nop_sel, if_id_squash,
           forward_mx1, forward_mx2, forward_mx3, forward_pc,
           mem_error, stall_count, annul_count
  );
endinterface

// File: rtl/pipeline_sequencer.sv
// Hazard/sequence controller for the 5-stage SPARC pipeline: latch enables, bubble/squash,
// operand and PC forwarding selects, data-memory freeze with timeout, debug event counters.
module pipeline_sequencer #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input logic                 clk,
  input logic                 clr,
  pipeline_sequencer_if.slave bus
);

  localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned WaitW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic [1:0] {StHold, StRun, StMemWait} state_e;

  state_e           state_q, state_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, annul_cnt_q, annul_cnt_d;
  logic             mem_error_q, mem_error_d;

  logic [4:0] le;  // {PC, IF/ID, ID/EX, EX/MEM, MEM/WB}
  logic       nop_sel, squash;
  logic [1:0] fwd_pc;
  logic       ex_v, mem_v, wb_v, load_use, mem_stall, annul;

  function automatic logic [1:0] fwd_sel(input logic use_r, input logic [4:0] r,
                                         input logic ex_ok, input logic [4:0] ex_r,
                                         input logic mem_ok, input logic [4:0] mem_r,
                                         input logic wb_ok, input logic [4:0] wb_r);
    if (!use_r || r == 5'd0)        return 2'd0;
    else if (ex_ok && ex_r == r)    return 2'd3;
    else if (mem_ok && mem_r == r)  return 2'd2;
    else if (wb_ok && wb_r == r)    return 2'd1;
    else                            return 2'd0;
  endfunction

  assign ex_v  = bus.ex_rf_en  && bus.ex_rd  != 5'd0;
  assign mem_v = bus.mem_rf_en && bus.mem_rd != 5'd0;
  assign wb_v  = bus.wb_rf_en  && bus.wb_rd  != 5'd0;

  assign mem_stall = bus.mem_req && !bus.mem_ready;
  assign load_use  = bus.ex_load && ex_v &&
                     ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_rd) ||
                      (bus.id_use_rs2 && bus.id_rs2 == bus.ex_rd) ||
                      (bus.id_use_rd  && bus.id_rd  == bus.ex_rd));
  assign annul     = bus.id_branch && bus.id_a && !bus.branch_taken;

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    stall_cnt_d = stall_cnt_q;
    annul_cnt_d = annul_cnt_q;
    mem_error_d = mem_error_q;
    le          = 5'b00000;
    nop_sel     = 1'b0;
    squash      = 1'b0;
    fwd_pc      = 2'd0;
    unique case (state_q)
      StHold: begin
        nop_sel = 1'b1;
        squash  = 1'b1;
        if (hold_cnt_q == HoldW'(HOLD_CYCLES - 1)) state_d = StRun;
        else                                       hold_cnt_d = hold_cnt_q + 1'b1;
      end
      StRun: begin
        if (mem_stall) begin
          state_d    = StMemWait;
          wait_cnt_d = '0;
        end else if (load_use) begin
          // Freeze PC and IF/ID, push a bubble into ID/EX; branch re-evaluates next cycle.
          le      = 5'b00111;
          nop_sel = 1'b1;
          if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
        end else begin
          le = 5'b11111;
          if (bus.id_jmpl)                                           fwd_pc = 2'd2;
          else if (bus.id_call || (bus.id_branch && bus.branch_taken)) fwd_pc = 2'd1;
          if (annul) begin
            squash = 1'b1;
            if (annul_cnt_q != '1) annul_cnt_d = annul_cnt_q + 1'b1;
          end
        end
      end
      StMemWait: begin
        if (bus.mem_ready) begin
          le      = 5'b11111;
          state_d = StRun;
        end else if (wait_cnt_q == WaitW'(MEM_TIMEOUT - 1)) begin
          mem_error_d = 1'b1;
          state_d     = StRun;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = StHold;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q     <= StHold;
      hold_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      annul_cnt_q <= '0;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      annul_cnt_q <= annul_cnt_d;
      mem_error_q <= mem_error_d;
    end
  end

  assign bus.pc_le        = le[4];
  assign bus.if_id_le     = le[3];
  assign bus.id_ex_le     = le[2];
  assign bus.ex_mem_le    = le[1];
  assign bus.mem_wb_le    = le[0];
  assign bus.nop_sel      = nop_sel;
  assign bus.if_id_squash = squash;
  assign bus.forward_pc   = fwd_pc;
  assign bus.forward_mx1  = fwd_sel(bus.id_use_rs1, bus.id_rs1, ex_v, bus.ex_rd,
                                    mem_v, bus.mem_rd, wb_v, bus.wb_rd);
  assign bus.forward_mx2  = fwd_sel(bus.id_use_rs2, bus.id_rs2, ex_v, bus.ex_rd,
                                    mem_v, bus.mem_rd, wb_v, bus.wb_rd);
  assign bus.forward_mx3  = fwd_sel(bus.id_use_rd, bus.id_rd, ex_v, bus.ex_rd,
                                    mem_v, bus.mem_rd, wb_v, bus.wb_rd);
  assign bus.mem_error    = mem_error_q;
  assign bus.stall_count  = stall_cnt_q;
  assign bus.annul_count  = annul_cnt_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer: reset hold, load-use, forwarding, annul,
// data-memory freeze and timeout.
module tb_pipeline_sequencer;

  logic clk = 1'b0;
  logic clr = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  pipeline_sequencer_if #(.CNT_W(16)) bus_if ();

  pipeline_sequencer #(
    .HOLD_CYCLES(4),
    .MEM_TIMEOUT(15),
    .CNT_W      (16)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus_if)
  );

  logic [4:0] les;
  assign les = {bus_if.pc_le, bus_if.if_id_le, bus_if.id_ex_le, bus_if.ex_mem_le,
                bus_if.mem_wb_le};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus_if.id_rs1 = 5'd0; bus_if.id_rs2 = 5'd0; bus_if.id_rd = 5'd0;
    bus_if.id_use_rs1 = 1'b0; bus_if.id_use_rs2 = 1'b0; bus_if.id_use_rd = 1'b0;
    bus_if.id_branch = 1'b0; bus_if.id_a = 1'b0; bus_if.branch_taken = 1'b0;
    bus_if.id_call = 1'b0; bus_if.id_jmpl = 1'b0;
    bus_if.ex_rd = 5'd0; bus_if.mem_rd = 5'd0; bus_if.wb_rd = 5'd0;
    bus_if.ex_rf_en = 1'b0; bus_if.mem_rf_en = 1'b0; bus_if.wb_rf_en = 1'b0;
    bus_if.ex_load = 1'b0; bus_if.mem_req = 1'b0; bus_if.mem_ready = 1'b0;
  endtask

  initial begin
    clear_inputs();
    clr = 1'b0;
    tick();
    tick();
    check("reset_les", les, 5'b00000);
    check("reset_nop", bus_if.nop_sel, 1'b1);
    check("reset_squash", bus_if.if_id_squash, 1'b1);
    check("reset_stall_cnt", bus_if.stall_count, 0);
    check("reset_annul_cnt", bus_if.annul_count, 0);
    check("reset_mem_error", bus_if.mem_error, 1'b0);

    // Four frozen cycles after clr rises, then RUN.
    clr = 1'b1;
    #1;
    check("hold_cycle0", les, 5'b00000);
    for (int i = 1; i < 4; i++) begin
      tick();
      check("hold_cycle", les, 5'b00000);
    end
    tick();
    check("run_les", les, 5'b11111);
    check("run_nop", bus_if.nop_sel, 1'b0);
    check("run_squash", bus_if.if_id_squash, 1'b0);

    // Load-use on rs1.
    bus_if.ex_load = 1'b1; bus_if.ex_rf_en = 1'b1; bus_if.ex_rd = 5'd5;
    bus_if.id_rs1 = 5'd5; bus_if.id_use_rs1 = 1'b1;
    #1;
    check("lu_les", les, 5'b00111);
    check("lu_nop", bus_if.nop_sel, 1'b1);
    check("lu_mx1", bus_if.forward_mx1, 2'd3);
    tick();
    check("lu_stall_cnt", bus_if.stall_count, 1);
    bus_if.ex_load = 1'b0; bus_if.ex_rf_en = 1'b0; bus_if.ex_rd = 5'd0;
    bus_if.mem_rd = 5'd5; bus_if.mem_rf_en = 1'b1;
    #1;
    check("lu_after_les", les, 5'b11111);
    check("lu_after_mx1", bus_if.forward_mx1, 2'd2);
    tick();
    check("lu_after_stall_cnt", bus_if.stall_count, 1);

    // Forwarding priority EX > MEM > WB > port.
    clear_inputs();
    bus_if.ex_rd = 5'd7; bus_if.mem_rd = 5'd7; bus_if.wb_rd = 5'd7;
    bus_if.ex_rf_en = 1'b1; bus_if.mem_rf_en = 1'b1; bus_if.wb_rf_en = 1'b1;
    bus_if.id_rs2 = 5'd7; bus_if.id_use_rs2 = 1'b1;
    bus_if.id_rd = 5'd7;
    #1;
    check("fwd_mx2_ex", bus_if.forward_mx2, 2'd3);
    check("fwd_mx3_unused", bus_if.forward_mx3, 2'd0);
    bus_if.ex_rf_en = 1'b0;
    #1;
    check("fwd_mx2_mem", bus_if.forward_mx2, 2'd2);
    bus_if.mem_rf_en = 1'b0;
    bus_if.id_use_rd = 1'b1;
    #1;
    check("fwd_mx2_wb", bus_if.forward_mx2, 2'd1);
    check("fwd_mx3_wb", bus_if.forward_mx3, 2'd1);
    bus_if.wb_rf_en = 1'b0;
    #1;
    check("fwd_mx2_port", bus_if.forward_mx2, 2'd0);
    bus_if.ex_rd = 5'd0; bus_if.mem_rd = 5'd0; bus_if.wb_rd = 5'd0;
    bus_if.ex_rf_en = 1'b1; bus_if.mem_rf_en = 1'b1; bus_if.wb_rf_en = 1'b1;
    bus_if.id_rs2 = 5'd0;
    #1;
    check("fwd_mx2_r0", bus_if.forward_mx2, 2'd0);
    tick();

    // Branch annul and PC source.
    clear_inputs();
    bus_if.id_branch = 1'b1; bus_if.id_a = 1'b1; bus_if.branch_taken = 1'b0;
    #1;
    check("annul_squash", bus_if.if_id_squash, 1'b1);
    check("annul_fwdpc", bus_if.forward_pc, 2'd0);
    check("annul_les", les, 5'b11111);
    tick();
    check("annul_cnt1", bus_if.annul_count, 1);
    bus_if.branch_taken = 1'b1;
    #1;
    check("taken_squash", bus_if.if_id_squash, 1'b0);
    check("taken_fwdpc", bus_if.forward_pc, 2'd1);
    tick();
    check("taken_annul_cnt", bus_if.annul_count, 1);
    bus_if.id_branch = 1'b0; bus_if.branch_taken = 1'b0; bus_if.id_jmpl = 1'b1;
    bus_if.id_call = 1'b1;
    #1;
    check("jmpl_fwdpc", bus_if.forward_pc, 2'd2);
    bus_if.id_jmpl = 1'b0;
    #1;
    check("call_fwdpc", bus_if.forward_pc, 2'd1);

    // Stall beats annul.
    clear_inputs();
    bus_if.ex_load = 1'b1; bus_if.ex_rf_en = 1'b1; bus_if.ex_rd = 5'd9;
    bus_if.id_rd = 5'd9; bus_if.id_use_rd = 1'b1;
    bus_if.id_branch = 1'b1; bus_if.id_a = 1'b1; bus_if.id_call = 1'b1;
    #1;
    check("stall_annul_squash", bus_if.if_id_squash, 1'b0);
    check("stall_annul_fwdpc", bus_if.forward_pc, 2'd0);
    check("stall_annul_mx3", bus_if.forward_mx3, 2'd3);
    tick();
    check("stall_annul_acnt", bus_if.annul_count, 1);
    check("stall_annul_scnt", bus_if.stall_count, 2);

    // Memory wait of three frozen cycles, resume on the fourth.
    clear_inputs();
    bus_if.mem_req = 1'b1;
    #1;
    check("mw_c1_les", les, 5'b00000);
    tick();
    check("mw_c2_les", les, 5'b00000);
    tick();
    check("mw_c3_les", les, 5'b00000);
    tick();
    bus_if.mem_ready = 1'b1;
    #1;
    check("mw_c4_les", les, 5'b11111);
    tick();
    bus_if.mem_req = 1'b0; bus_if.mem_ready = 1'b0;
    #1;
    check("mw_after_les", les, 5'b11111);
    check("mw_no_error", bus_if.mem_error, 1'b0);

    // Timeout: 15 MEM_WAIT cycles without ready.
    bus_if.mem_req = 1'b1;
    tick();
    bus_if.mem_req = 1'b0;
    for (int i = 0; i < 15; i++) begin
      #1;
      check("to_wait", {les, bus_if.mem_error}, 6'b000000);
      tick();
    end
    check("to_error", bus_if.mem_error, 1'b1);
    check("to_run_les", les, 5'b11111);
    tick();
    check("to_sticky", bus_if.mem_error, 1'b1);

    // clr mid-freeze returns to HOLD and clears everything.
    bus_if.mem_req = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    check("clr_les", les, 5'b00000);
    check("clr_error", bus_if.mem_error, 1'b0);
    check("clr_stall_cnt", bus_if.stall_count, 0);
    check("clr_annul_cnt", bus_if.annul_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
